display_sum4b: RTL
==================

DISPLAY_SUM4B -- requirements
Module: display_sum4b

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: the number of clock cycles each digit stays lit; legal range is 2 or more.
REQ-002 Parameter BLANK_ZERO, default 1: when 1, a tens digit of 0 is blanked.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 Si  input  4  sum bits from the 4-bit adder stage.
REQ-006 Co  input  1  carry-out from the 4-bit adder stage.
REQ-007 hold  input  1  when 1, the displayed value is frozen.
REQ-008 SSeg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
REQ-009 An  output  2  digit anodes, active-low; An[0] is the units digit and An[1] is the tens digit.

Function
REQ-010 The block SHALL hold a 5-bit register val_q; on each edge with rst=1 it loads {Co,Si} if hold=0, and keeps its value if hold=1.
REQ-011 The block SHALL treat val_q as unsigned 0..31 and derive tens = val_q/10 (0..3) and units = val_q mod 10 combinationally.
REQ-012 The block SHALL have a refresh counter cnt counting 0..REFRESH_DIV-1; it increments every cycle and wraps to 0 after REFRESH_DIV-1.
REQ-013 Digit select sel SHALL toggle on the edge where cnt wraps, and only then.
REQ-014 The outputs SSeg and An SHALL be registered, computed from the pre-edge values of sel and val_q.
REQ-015 When sel=0, the next outputs SHALL be An=2'b10 and SSeg=code(units).
REQ-016 When sel=1, the next outputs SHALL be An=2'b01 and SSeg=code(tens).
- Exception: if BLANK_ZERO=1 and tens=0, then An=2'b11 and SSeg=7'b1111111.
REQ-017 Segment code table (code(n)):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
REQ-018 Latency SHALL be 2 clock edges from a change on {Co,Si} (with hold=0) to the new digit on SSeg, provided that digit is being scanned.
REQ-019 An SHALL never have both bits low in any cycle.
REQ-020 Boundary: val_q=31 SHALL display tens=3 and units=1; val_q=10 SHALL display tens=1 and units=0 (the units zero is never blanked).
REQ-021 Simultaneous hold=1 and an input change: the input change SHALL be ignored and val_q keeps its old value.
REQ-022 A hold release SHALL load the current {Co,Si} on the first edge with hold=0.
REQ-023 Counter wrap and an input change on the same edge SHALL both take effect; the new sel is used with the new val_q on the following edge.

Reset
REQ-024 On any edge with rst=0 the block SHALL set val_q=0, cnt=0, sel=0, An=2'b11 and SSeg=7'b1111111, regardless of hold or the inputs.
REQ-025 Reset asserted mid-scan SHALL take effect on that same edge with no partial digit output.
- The first edge after rst returns to 1 SHALL produce An=2'b10 and SSeg=1000000.
REQ-026 The block SHALL have no asynchronous reset path; rst toggling between edges has no effect.

Verification (bench uses REFRESH_DIV=4)
REQ-027 Reset for 3 cycles, release, Si=0, Co=0 -> An=11 and SSeg=1111111 during reset; first edge after release gives An=10 and SSeg=1000000.
REQ-028 Co=1, Si=4'hF (31) -> units slot shows An=10, SSeg=1111001; tens slot shows An=01, SSeg=0110000; slots alternate every 4 cycles.
REQ-029 Si=4'h7, Co=0, BLANK_ZERO=1 -> units slot shows SSeg=1111000; tens slot shows An=11, SSeg=1111111.
- Repeat with BLANK_ZERO=0 -> tens slot shows An=01, SSeg=1000000.
REQ-030 Si=4'hA, Co=0 -> tens=1, units=0.
- Then set hold=1 and Si=4'h3 -> display stays 10.
- Then set hold=0 -> units shows 0110000 two edges after release, while sel=0.
REQ-031 rst=0 asserted for one edge during the tens slot with val 25 -> outputs blank on that edge, then the units slot restarts.
- The displayed value then becomes the current inputs.
REQ-032 Random {Co,Si} every 1..20 cycles for 10000 cycles, checked against a reference model:
- SSeg and An match the model every cycle.
- An is never 00.

Source files
------------

// File: rtl/display_sum4b.sv
// Two-digit seven-segment scanner for a 5-bit adder result {Co,Si}.
// Shows val/10 and val%10 on alternate slots of REFRESH_DIV cycles each, with registered outputs.
module display_sum4b #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_ZERO  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Si,
  input  logic       Co,
  input  logic       hold,
  output logic [6:0] SSeg,
  output logic [1:0] An
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  logic [4:0]       val_q;
  logic [CNT_W-1:0] cnt;
  logic             sel;
  logic [1:0]       tens;
  logic [3:0]       units;
  logic [1:0]       an_d;
  logic [6:0]       seg_d;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = SEG_OFF;
    endcase
  endfunction

  // Range compare instead of a divider: val_q never exceeds 31, so tens is 0..3.
  always_comb begin
    tens  = 2'd0;
    units = val_q[3:0];
    if (val_q >= 5'd30) begin
      tens  = 2'd3;
      units = 4'(val_q - 5'd30);
    end else if (val_q >= 5'd20) begin
      tens  = 2'd2;
      units = 4'(val_q - 5'd20);
    end else if (val_q >= 5'd10) begin
      tens  = 2'd1;
      units = 4'(val_q - 5'd10);
    end
  end

  always_comb begin
    an_d  = 2'b10;
    seg_d = seg_code(units);
    if (sel) begin
      if (BLANK_ZERO && tens == 2'd0) begin
        an_d  = 2'b11;
        seg_d = SEG_OFF;
      end else begin
        an_d  = 2'b01;
        seg_d = seg_code({2'b00, tens});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      val_q <= '0;
      cnt   <= '0;
      sel   <= 1'b0;
      An    <= 2'b11;
      SSeg  <= SEG_OFF;
    end else begin
      if (!hold) val_q <= {Co, Si};
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        sel <= ~sel;
      end else begin
        cnt <= cnt + 1'b1;
      end
      An   <= an_d;
      SSeg <= seg_d;
    end
  end

endmodule
